// File: rtl/fp_align_add_pipe.sv
// Three-stage mantissa compare/align/add for the FP adder: swaps operands by magnitude,
// right-aligns the smaller one with guard/round/sticky, then adds or subtracts.
module fp_align_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 24
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             S_A,
   input  logic             S_B,
   input  logic [EXP_W-1:0] E_A,
   input  logic [EXP_W-1:0] E_B,
   input  logic [MAN_W-1:0] M_A,
   input  logic [MAN_W-1:0] M_B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             S_Result,
   output logic [EXP_W-1:0] E_Result,
   output logic [MAN_W-1:0] M_Result,
   output logic             Carry,
   output logic [2:0]       GRS,
   output logic             Zero
);

   localparam int EXT_W = MAN_W + 3;

   // Handshake: a transfer happens on a rising edge where valid && ready. The whole pipe
   // advances as one unit whenever the output register is empty or being drained, so
   // in_ready is that advance condition and out_valid/outputs hold while stalled.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage 1: compare/swap
   logic             a_big;
   logic             v1;
   logic             s_big1;
   logic             eff_sub1;
   logic [EXP_W-1:0] e_big1;
   logic [EXP_W-1:0] diff1;
   logic [MAN_W-1:0] m_big1;
   logic [MAN_W-1:0] m_small1;

   // Ties go to A so the result sign of an exact cancellation is well defined.
   assign a_big = {E_A, M_A} >= {E_B, M_B};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         v1       <= 1'b0;
         s_big1   <= 1'b0;
         eff_sub1 <= 1'b0;
         e_big1   <= '0;
         diff1    <= '0;
         m_big1   <= '0;
         m_small1 <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         if (in_valid) begin
            s_big1   <= a_big ? S_A : S_B;
            eff_sub1 <= S_A ^ S_B;
            e_big1   <= a_big ? E_A : E_B;
            diff1    <= a_big ? (E_A - E_B) : (E_B - E_A);
            m_big1   <= a_big ? M_A : M_B;
            m_small1 <= a_big ? M_B : M_A;
         end
      end
   end

   // Stage 2: align
   logic [EXT_W-1:0] small_ext;
   logic [EXT_W-1:0] lost_mask;
   logic [EXT_W-1:0] aligned;
   logic             v2;
   logic             s_big2;
   logic             eff_sub2;
   logic [EXP_W-1:0] e_big2;
   logic [EXT_W-1:0] big_ext2;
   logic [EXT_W-1:0] small_ext2;

   always_comb begin
      small_ext = {m_small1, 3'b000};
      lost_mask = ~({EXT_W{1'b1}} << diff1);
      aligned   = (small_ext >> diff1) | EXT_W'(|(small_ext & lost_mask));
      // Everything shifted out: only the sticky bit survives.
      if (32'(diff1) >= 32'(EXT_W)) begin
         aligned = {{(EXT_W-1){1'b0}}, |m_small1};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         v2         <= 1'b0;
         s_big2     <= 1'b0;
         eff_sub2   <= 1'b0;
         e_big2     <= '0;
         big_ext2   <= '0;
         small_ext2 <= '0;
      end else if (adv) begin
         v2 <= v1;
         if (v1) begin
            s_big2     <= s_big1;
            eff_sub2   <= eff_sub1;
            e_big2     <= e_big1;
            big_ext2   <= {m_big1, 3'b000};
            small_ext2 <= aligned;
         end
      end
   end

   // Stage 3: add/sub; big >= small so the subtract never borrows.
   logic [EXT_W:0] sum_raw;
   logic           res_zero;

   always_comb begin
      if (eff_sub2) sum_raw = {1'b0, big_ext2 - small_ext2};
      else          sum_raw = {1'b0, big_ext2} + {1'b0, small_ext2};
      res_zero = (sum_raw == '0);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         out_valid <= 1'b0;
         S_Result  <= 1'b0;
         E_Result  <= '0;
         M_Result  <= '0;
         Carry     <= 1'b0;
         GRS       <= 3'b000;
         Zero      <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         if (v2) begin
            S_Result                 <= s_big2 & ~res_zero;
            E_Result                 <= e_big2;
            {Carry, M_Result, GRS}   <= sum_raw;
            Zero                     <= res_zero;
         end
      end
   end

endmodule

// File: tb/tb_fp_align_add_pipe.sv
// Directed bench for fp_align_add_pipe: single-op vectors, backpressure stream with an
// expected-result queue, and a mid-stream asynchronous reset.
module tb_fp_align_add_pipe;

   localparam int EXP_W = 8;
   localparam int MAN_W = 24;
   localparam int RW    = 1 + EXP_W + MAN_W + 1 + 3 + 1;
   localparam int OW    = 2 * (1 + EXP_W + MAN_W);

   logic             Clk = 1'b0;
   logic             Reset;
   logic             in_valid;
   logic             in_ready;
   logic             S_A, S_B;
   logic [EXP_W-1:0] E_A, E_B;
   logic [MAN_W-1:0] M_A, M_B;
   logic             out_valid;
   logic             out_ready;
   logic             S_Result;
   logic [EXP_W-1:0] E_Result;
   logic [MAN_W-1:0] M_Result;
   logic             Carry;
   logic [2:0]       GRS;
   logic             Zero;

   int tests = 0;
   int fails = 0;
   logic [RW-1:0] exp_q[$];

   fp_align_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .S_A(S_A), .S_B(S_B), .E_A(E_A), .E_B(E_B), .M_A(M_A), .M_B(M_B),
      .out_valid(out_valid), .out_ready(out_ready),
      .S_Result(S_Result), .E_Result(E_Result), .M_Result(M_Result),
      .Carry(Carry), .GRS(GRS), .Zero(Zero)
   );

   // Clock and watchdog
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [RW-1:0] mk(input logic s, input logic [EXP_W-1:0] e,
                                        input logic [MAN_W-1:0] m, input logic c,
                                        input logic [2:0] grs, input logic z);
      return {s, e, m, c, grs, z};
   endfunction

   function automatic logic [OW-1:0] op(input logic sa, input logic [EXP_W-1:0] ea,
                                        input logic [MAN_W-1:0] ma, input logic sb,
                                        input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] mb);
      return {sa, ea, ma, sb, eb, mb};
   endfunction

   function automatic logic [RW-1:0] observed();
      return {S_Result, E_Result, M_Result, Carry, GRS, Zero};
   endfunction

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Driver tasks
   task automatic set_op(input logic [OW-1:0] o);
      {S_A, E_A, M_A, S_B, E_B, M_B} = o;
   endtask

   task automatic send_and_check(input string tag, input logic [OW-1:0] o, input logic [RW-1:0] expv);
      int lat;
      @(negedge Clk);
      set_op(o);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({tag, "_rdy"}, RW'(in_ready), RW'(1));
      @(negedge Clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge Clk);
         lat++;
      end
      check({tag, "_lat"}, RW'(lat), RW'(3));
      check(tag, observed(), expv);
   endtask

   logic [OW-1:0] op_t[5];
   logic [RW-1:0] exp_t[5];
   logic [RW-1:0] held;
   logic          stalled_prev;
   int            sent;
   int            got;

   initial begin
      op_t[0] = op(1'b0, 8'd30, 24'h800000, 1'b1, 8'd50, 24'hFFFFFF);
      exp_t[0] = mk(1'b1, 8'd50, 24'hFFFFF7, 1'b0, 3'b000, 1'b0);
      op_t[1] = op(1'b0, 8'd10, 24'h800000, 1'b0, 8'd10, 24'h800000);
      exp_t[1] = mk(1'b0, 8'd10, 24'h000000, 1'b1, 3'b000, 1'b0);
      op_t[2] = op(1'b0, 8'd100, 24'h800000, 1'b0, 8'd50, 24'h000001);
      exp_t[2] = mk(1'b0, 8'd100, 24'h800000, 1'b0, 3'b001, 1'b0);
      op_t[3] = op(1'b0, 8'd11, 24'h800000, 1'b0, 8'd10, 24'h800001);
      exp_t[3] = mk(1'b0, 8'd11, 24'hC00000, 1'b0, 3'b100, 1'b0);
      op_t[4] = op(1'b0, 8'd15, 24'h800000, 1'b1, 8'd10, 24'h800001);
      exp_t[4] = mk(1'b0, 8'd15, 24'h7BFFFF, 1'b0, 3'b111, 1'b0);

      // Reset state
      Reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_op('0);
      repeat (2) @(negedge Clk);
      check("rst_outputs", observed(), '0);
      check("rst_out_valid", RW'(out_valid), RW'(0));
      check("rst_in_ready", RW'(in_ready), RW'(1));
      Reset = 1'b0;

      // Directed single operations
      send_and_check("align_sub", op_t[0], exp_t[0]);
      send_and_check("add_carry", op_t[1], exp_t[1]);
      send_and_check("full_shift", op_t[2], exp_t[2]);
      send_and_check("cancel", op(1'b0, 8'd20, 24'hC00000, 1'b1, 8'd20, 24'hC00000),
                     mk(1'b0, 8'd20, 24'h0, 1'b0, 3'b000, 1'b1));
      send_and_check("cancel_neg_a", op(1'b1, 8'd20, 24'hC00000, 1'b0, 8'd20, 24'hC00000),
                     mk(1'b0, 8'd20, 24'h0, 1'b0, 3'b000, 1'b1));
      send_and_check("diff26_sticky", op(1'b0, 8'd40, 24'h800000, 1'b0, 8'd14, 24'hC00000),
                     mk(1'b0, 8'd40, 24'h800000, 1'b0, 3'b001, 1'b0));
      send_and_check("diff27", op(1'b0, 8'd37, 24'h800000, 1'b0, 8'd10, 24'h800000),
                     mk(1'b0, 8'd37, 24'h800000, 1'b0, 3'b001, 1'b0));
      send_and_check("guard_bit", op_t[3], exp_t[3]);
      send_and_check("sub_sticky", op_t[4], exp_t[4]);
      send_and_check("swap_same_exp", op(1'b0, 8'd5, 24'h900000, 1'b1, 8'd5, 24'hA00000),
                     mk(1'b1, 8'd5, 24'h100000, 1'b0, 3'b000, 1'b0));

      // Backpressure: 5 back-to-back ops, out_ready low for 4 cycles mid-stream
      sent = 0;
      got = 0;
      stalled_prev = 1'b0;
      held = '0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         @(negedge Clk);
         out_ready = !(c >= 4 && c <= 7);
         in_valid  = (sent < 5);
         if (sent < 5) set_op(op_t[sent]);
         #1;
         if (stalled_prev) check("bp_hold", observed(), held);
         if (out_valid && !out_ready) begin
            check("bp_in_ready", RW'(in_ready), RW'(0));
            held = observed();
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("bp_extra_out", RW'(out_valid), RW'(0));
            else check("bp_data", observed(), exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_t[sent]);
            sent++;
         end
      end
      check("bp_count", RW'(got), RW'(5));
      check("bp_queue_empty", RW'(exp_q.size()), RW'(0));
      @(negedge Clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         check("bp_no_dup", RW'(out_valid), RW'(0));
      end

      // Reset with three ops in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         set_op(op_t[i]);
         @(negedge Clk);
      end
      in_valid = 1'b0;
      check("inflight_valid", RW'(out_valid), RW'(1));
      #2;
      Reset = 1'b1;
      #1;
      check("mid_rst_outputs", observed(), '0);
      check("mid_rst_out_valid", RW'(out_valid), RW'(0));
      check("mid_rst_in_ready", RW'(in_ready), RW'(1));
      @(negedge Clk);
      check("mid_rst_held", RW'(out_valid), RW'(0));
      Reset = 1'b0;
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge Clk);
         check("post_rst_no_stale", RW'(out_valid), RW'(0));
      end
      send_and_check("post_rst_op", op_t[1], exp_t[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
